// File: rtl/l2_cache.sv
// 4-way set-associative write-through/write-allocate L2; hits respond in 1 cycle, misses stall (ready=0) until mem_ready.
// Optional hit/miss counters are enabled by defining L2_CACHE_STATS_EN.
module l2_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 512,
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_WAYS   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [ADDR_WIDTH-1:0]                  l1_cache_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  l1_cache_data_in,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  l1_block_data_out,
    output logic                                   l1_block_valid,
    input  logic                                   l1_cache_read,
    input  logic                                   l1_cache_write,
    output logic                                   l1_cache_ready,
    output logic                                   l1_cache_hit,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_data_block,
    input  logic                                   mem_ready,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_data_out,
    output logic                                   mem_read,
`ifdef L2_CACHE_STATS_EN
    output logic [31:0]                            hit_count,
    output logic [31:0]                            miss_count,
`endif
    output logic                                   mem_write
);

    localparam int SETS  = CACHE_SIZE / NUM_WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
    typedef enum logic {IDLE, FETCH} state_t;

    state_t state_q, state_d;

    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [WAY_W-1:0]    age_q   [SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
    block_t              data_q  [SETS][NUM_WAYS];

    logic [ADDR_WIDTH-1:0] lk_addr;
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic [WAY_W-1:0]      hit_way, inv_way, lru_way, acc_way;
    logic                  inv_found;
    logic [WAY_W-1:0]      best_age, acc_old_age;
    logic [WAY_W-1:0]      age_new [NUM_WAYS];

    logic accept, do_write, do_rd_hit, do_rd_miss, do_fill, install, lru_upd;
    block_t install_dat;

    // In FETCH the outstanding miss address is held on mem_addr, so it doubles as the lookup key.
    always_comb begin
        lk_addr = (state_q == IDLE) ? l1_cache_addr : mem_addr;
        lk_idx  = lk_addr[IDX_W-1:0];
        lk_tag  = lk_addr[ADDR_WIDTH-1:IDX_W];

        lk_hit  = 1'b0;
        hit_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (valid_q[lk_idx][i] && tag_q[lk_idx][i] == lk_tag) begin
                lk_hit  = 1'b1;
                hit_way = WAY_W'(i);
            end
        end

        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_q[lk_idx][i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end

        lru_way  = '0;
        best_age = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (age_q[lk_idx][i] > best_age) begin
                best_age = age_q[lk_idx][i];
                lru_way  = WAY_W'(i);
            end
        end

        acc_way = lk_hit ? hit_way : (inv_found ? inv_way : lru_way);
    end

    always_comb begin
        accept     = (state_q == IDLE) && (l1_cache_read || l1_cache_write);
        do_write   = (state_q == IDLE) && l1_cache_write;
        do_rd_hit  = (state_q == IDLE) && !l1_cache_write && l1_cache_read && lk_hit;
        do_rd_miss = (state_q == IDLE) && !l1_cache_write && l1_cache_read && !lk_hit;
        do_fill    = (state_q == FETCH) && mem_ready;
        install    = do_write || do_fill;
        lru_upd    = do_write || do_rd_hit || do_fill;
        install_dat = do_write ? l1_cache_data_in : mem_data_block;
    end

    // A freshly allocated (previously invalid) way counts as oldest so every valid way ages behind it.
    always_comb begin
        acc_old_age = valid_q[lk_idx][acc_way] ? age_q[lk_idx][acc_way] : {WAY_W{1'b1}};
        for (int i = 0; i < NUM_WAYS; i++) begin
            age_new[i] = age_q[lk_idx][i];
            if (WAY_W'(i) == acc_way)
                age_new[i] = '0;
            else if (age_q[lk_idx][i] < acc_old_age)
                age_new[i] = age_q[lk_idx][i] + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_rd_miss) state_d = FETCH;
            FETCH:   if (mem_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[s][w] <= '0;
            end
        end else begin
            if (install)
                valid_q[lk_idx][acc_way] <= 1'b1;
            if (lru_upd)
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[lk_idx][w] <= age_new[w];
        end
    end

    // Tag and data storage need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[lk_idx][acc_way]  <= lk_tag;
            data_q[lk_idx][acc_way] <= install_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_block_data_out <= '0;
            l1_block_valid    <= 1'b0;
            l1_cache_ready    <= 1'b1;
            l1_cache_hit      <= 1'b0;
            mem_addr          <= '0;
            mem_data_out      <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
        end else if (do_write) begin
            mem_write      <= 1'b1;
            mem_addr       <= l1_cache_addr;
            mem_data_out   <= l1_cache_data_in;
            l1_cache_ready <= 1'b1;
            l1_cache_hit   <= lk_hit;
            l1_block_valid <= 1'b0;
        end else if (do_rd_hit) begin
            l1_block_data_out <= data_q[lk_idx][hit_way];
            l1_block_valid    <= 1'b1;
            l1_cache_hit      <= 1'b1;
            l1_cache_ready    <= 1'b1;
            mem_write         <= 1'b0;
        end else if (do_rd_miss) begin
            l1_block_valid <= 1'b0;
            l1_cache_ready <= 1'b0;
            l1_cache_hit   <= 1'b0;
            mem_read       <= 1'b1;
            mem_addr       <= l1_cache_addr;
            mem_write      <= 1'b0;
        end else if (do_fill) begin
            l1_block_data_out <= mem_data_block;
            l1_block_valid    <= 1'b1;
            l1_cache_ready    <= 1'b1;
            l1_cache_hit      <= 1'b0;
            mem_read          <= 1'b0;
        end
    end

`ifdef L2_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (lk_hit)
                hit_count <= hit_count + 32'd1;
            else
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Directed table-driven bench for l2_cache plus a hand-written reset-during-fetch sequence.
module tb_l2_cache;

    typedef logic [31:0][31:0] block_t;

    logic         clk;
    logic         rst_n;
    logic [10:0]  l1_cache_addr;
    block_t       l1_cache_data_in;
    block_t       l1_block_data_out;
    logic         l1_block_valid;
    logic         l1_cache_read;
    logic         l1_cache_write;
    logic         l1_cache_ready;
    logic         l1_cache_hit;
    block_t       mem_data_block;
    logic         mem_ready;
    logic [10:0]  mem_addr;
    block_t       mem_data_out;
    logic         mem_read;
    logic         mem_write;
`ifdef L2_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    l2_cache dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l1_cache_addr     (l1_cache_addr),
        .l1_cache_data_in  (l1_cache_data_in),
        .l1_block_data_out (l1_block_data_out),
        .l1_block_valid    (l1_block_valid),
        .l1_cache_read     (l1_cache_read),
        .l1_cache_write    (l1_cache_write),
        .l1_cache_ready    (l1_cache_ready),
        .l1_cache_hit      (l1_cache_hit),
        .mem_data_block    (mem_data_block),
        .mem_ready         (mem_ready),
        .mem_addr          (mem_addr),
        .mem_data_out      (mem_data_out),
        .mem_read          (mem_read),
`ifdef L2_CACHE_STATS_EN
        .hit_count         (hit_count),
        .miss_count        (miss_count),
`endif
        .mem_write         (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [10:0] addr;
        logic [31:0] wbase;
        logic        mrdy;
        logic [31:0] mbase;
        logic        e_ready, e_valid, e_hit, e_mrd, e_mwr;
        logic [10:0] e_maddr;
        logic        chk_d;
        int          d_idx;
        logic [31:0] d_word;
        logic        chk_m;
        int          m_idx;
        logic [31:0] m_word;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    function automatic block_t mk(input logic [31:0] base);
        block_t b;
        for (int i = 0; i < 32; i++) b[i] = base ^ 32'(i);
        return b;
    endfunction

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [10:0] addr,
                                 input logic [31:0] wbase, input logic mrdy, input logic [31:0] mbase,
                                 input logic er, input logic ev, input logic eh, input logic emr,
                                 input logic emw, input logic [10:0] emaddr,
                                 input logic cd, input int di, input logic [31:0] dw,
                                 input logic cm, input int mi, input logic [31:0] mw);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wbase = wbase; v.mrdy = mrdy; v.mbase = mbase;
        v.e_ready = er; v.e_valid = ev; v.e_hit = eh; v.e_mrd = emr; v.e_mwr = emw; v.e_maddr = emaddr;
        v.chk_d = cd; v.d_idx = di; v.d_word = dw; v.chk_m = cm; v.m_idx = mi; v.m_word = mw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        l1_cache_read    = v.rd;
        l1_cache_write   = v.wr;
        l1_cache_addr    = v.addr;
        l1_cache_data_in = mk(v.wbase);
        mem_ready        = v.mrdy;
        mem_data_block   = mk(v.mbase);
        @(posedge clk);
        #1;
        chk({tag, ".ready"},    32'(l1_cache_ready), 32'(v.e_ready));
        chk({tag, ".valid"},    32'(l1_block_valid), 32'(v.e_valid));
        chk({tag, ".hit"},      32'(l1_cache_hit),   32'(v.e_hit));
        chk({tag, ".mem_read"}, 32'(mem_read),       32'(v.e_mrd));
        chk({tag, ".mem_write"},32'(mem_write),      32'(v.e_mwr));
        chk({tag, ".mem_addr"}, 32'(mem_addr),       32'(v.e_maddr));
        if (v.chk_d) chk({tag, ".data_out"},     l1_block_data_out[v.d_idx], v.d_word);
        if (v.chk_m) chk({tag, ".mem_data_out"}, mem_data_out[v.m_idx],      v.m_word);
    endtask

    initial begin
        rst_n = 1'b0;
        l1_cache_read = 1'b0; l1_cache_write = 1'b0; l1_cache_addr = '0;
        l1_cache_data_in = '0; mem_ready = 1'b0; mem_data_block = '0;

        //      rd wr addr    wbase         mrdy mbase         rdy vld hit mrd mwr maddr   cd di  dword         cm mi mword
        // 1: read miss, stall, fill
        vecs.push_back(mkv(1,0,11'h00A,32'h0,        0,32'h0,          0,0,0,1,0,11'h00A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        0,32'h0,          0,0,0,1,0,11'h00A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'hDEADBEEF,   1,1,0,0,0,11'h00A, 1,0,32'hDEADBEEF,   0,0,32'h0));
        // 2: read hit
        vecs.push_back(mkv(1,0,11'h00A,32'h0,        0,32'h0,          1,1,1,0,0,11'h00A, 1,5,32'hDEADBEEA,   0,0,32'h0));
        // 3,4: write miss then write hit, then read back
        vecs.push_back(mkv(0,1,11'h014,32'hA5A5A5A5, 0,32'h0,          1,0,0,0,1,11'h014, 0,0,32'h0,          1,1,32'hA5A5A5A4));
        vecs.push_back(mkv(0,1,11'h014,32'h5A5A5A5A, 0,32'h0,          1,0,1,0,1,11'h014, 0,0,32'h0,          1,0,32'h5A5A5A5A));
        vecs.push_back(mkv(1,0,11'h014,32'h0,        0,32'h0,          1,1,1,0,0,11'h014, 1,0,32'h5A5A5A5A,   0,0,32'h0));
        // 5: fill set 0x0A, evict LRU
        vecs.push_back(mkv(1,0,11'h00A,32'h0,        0,32'h0,          1,1,1,0,0,11'h014, 1,0,32'hDEADBEEF,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h08A,32'h0,        0,32'h0,          0,0,0,1,0,11'h08A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'h11110000,   1,1,0,0,0,11'h08A, 1,3,32'h11110003,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h10A,32'h0,        0,32'h0,          0,0,0,1,0,11'h10A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'h22220000,   1,1,0,0,0,11'h10A, 1,0,32'h22220000,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h18A,32'h0,        0,32'h0,          0,0,0,1,0,11'h18A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'h33330000,   1,1,0,0,0,11'h18A, 1,0,32'h33330000,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h20A,32'h0,        0,32'h0,          0,0,0,1,0,11'h20A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'h44440000,   1,1,0,0,0,11'h20A, 1,0,32'h44440000,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h08A,32'h0,        0,32'h0,          1,1,1,0,0,11'h20A, 1,3,32'h11110003,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h00A,32'h0,        0,32'h0,          0,0,0,1,0,11'h00A, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'hDEADBEEF,   1,1,0,0,0,11'h00A, 1,0,32'hDEADBEEF,   0,0,32'h0));
        // read+write together: write wins
        vecs.push_back(mkv(1,1,11'h030,32'h12340000, 0,32'h0,          1,0,0,0,1,11'h030, 0,0,32'h0,          1,7,32'h12340007));
        vecs.push_back(mkv(1,0,11'h030,32'h0,        0,32'h0,          1,1,1,0,0,11'h030, 1,7,32'h12340007,   0,0,32'h0));
        // request during FETCH is ignored
        vecs.push_back(mkv(1,0,11'h0B0,32'h0,        0,32'h0,          0,0,0,1,0,11'h0B0, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,1,11'h0C0,32'h77770000, 0,32'h0,          0,0,0,1,0,11'h0B0, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'h55550000,   1,1,0,0,0,11'h0B0, 1,2,32'h55550002,   0,0,32'h0));
        vecs.push_back(mkv(1,0,11'h0C0,32'h0,        0,32'h0,          0,0,0,1,0,11'h0C0, 0,0,32'h0,          0,0,32'h0));
        vecs.push_back(mkv(0,0,11'h000,32'h0,        1,32'h66660000,   1,1,0,0,0,11'h0C0, 1,1,32'h66660001,   0,0,32'h0));

        #12;
        chk("rst.ready",     32'(l1_cache_ready), 32'd1);
        chk("rst.valid",     32'(l1_block_valid), 32'd0);
        chk("rst.hit",       32'(l1_cache_hit),   32'd0);
        chk("rst.mem_read",  32'(mem_read),       32'd0);
        chk("rst.mem_write", 32'(mem_write),      32'd0);
        chk("rst.mem_addr",  32'(mem_addr),       32'd0);
        chk("rst.data_out",  32'(|l1_block_data_out), 32'd0);
        chk("rst.mem_data",  32'(|mem_data_out),  32'd0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Reset while fetching aborts the fetch and forgets every line.
        apply(mkv(1,0,11'h1FA,32'h0,0,32'h0, 0,0,0,1,0,11'h1FA, 0,0,32'h0, 0,0,32'h0), "midrst.req");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.mem_read", 32'(mem_read),       32'd0);
        chk("midrst.ready",    32'(l1_cache_ready), 32'd1);
        chk("midrst.mem_addr", 32'(mem_addr),       32'd0);
        #3 rst_n = 1'b1;
        apply(mkv(1,0,11'h00A,32'h0,0,32'h0, 0,0,0,1,0,11'h00A, 0,0,32'h0, 0,0,32'h0), "midrst.rd00A");
        apply(mkv(0,0,11'h000,32'h0,1,32'h9999000F, 1,1,0,0,0,11'h00A, 1,15,32'h99990000, 0,0,32'h0), "midrst.fill");
        apply(mkv(1,0,11'h1FA,32'h0,0,32'h0, 0,0,0,1,0,11'h1FA, 0,0,32'h0, 0,0,32'h0), "midrst.rd1FA");
        apply(mkv(0,0,11'h000,32'h0,1,32'h0, 1,1,0,0,0,11'h1FA, 0,0,32'h0, 0,0,32'h0), "midrst.fill2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
